mem_access_unit: RTL

//  CPU-side initiator for the word-addressed, single-port data memory (1-cycle registered-address read).

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side initiator for a word-addressed, single-port data memory with a
// one-cycle registered-address read. Turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests
// into memory cycles. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
// Byte order is little-endian.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   req, wr, size, sign_ext      request strobe (sampled only when idle), store/load,
//                                access size, load extension mode
//   addr, wdata                  byte address, right-justified store data
//   busy, done, misaligned       status: busy, 1-cycle completion pulse, 1-cycle reject pulse
//   rdata                        load result, held until the next load completes
//   mem_addr, mem_data_in        memory word address and write data (registered)
//   mem_wr_rd                    0 = write, 1 = read; low only in the write state
//   mem_data_out                 memory read data, valid the cycle after the address is sampled
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wr_rd,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;

  state_e                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [1:0]              size_q, size_d;
  logic                    sign_q, sign_d;
  logic [1:0]              lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    misaligned_q, misaligned_d;

  logic                    bad_align;
  logic [7:0]              byte_val;
  logic [15:0]             half_val;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merged;

  assign bad_align = (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Lane extraction from the word returned by memory.
  assign byte_val = mem_data_out[{lane_q, 3'b000} +: 8];
  assign half_val = mem_data_out[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_data_out;
    case (size_q)
      2'b00:   load_val = {{(DATA_WIDTH - 8){sign_q & byte_val[7]}}, byte_val};
      2'b01:   load_val = {{(DATA_WIDTH - 16){sign_q & half_val[15]}}, half_val};
      default: load_val = mem_data_out;
    endcase
  end

  // Store data was parked right-justified in mem_data_in_q at accept; splice it into the lane.
  always_comb begin
    merged = mem_data_out;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = mem_data_in_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = mem_data_in_q[15:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    size_d        = size_q;
    sign_d        = sign_q;
    lane_d        = lane_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rdata_d       = rdata_q;
    done_d        = 1'b0;
    misaligned_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (bad_align) begin
            misaligned_d = 1'b1;
          end else begin
            wr_d          = wr;
            size_d        = size;
            sign_d        = sign_ext;
            lane_d        = addr[1:0];
            mem_addr_d    = addr[ADDR_WIDTH+1:2];
            mem_data_in_d = wdata;
            state_d       = (wr && (size == 2'b10)) ? StWrite : StRead;
          end
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        if (!wr_q) begin
          rdata_d = load_val;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          mem_data_in_d = merged;
          state_d       = StWrite;
        end
      end
      StWrite: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      size_q        <= 2'b00;
      sign_q        <= 1'b0;
      lane_q        <= 2'b00;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      lane_q        <= lane_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign misaligned  = misaligned_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  // Decoded from state so reset forces read mode immediately.
  assign mem_wr_rd   = (state_q != StWrite);

endmodule
